tts_monitor: RTL and testbench
==============================

// Module: tts_monitor
// PURPOSE
//   Receive-side monitor for the 4-bit TTS status link. Synchronises and
//   debounces the incoming TTS code, then decodes it into a priority class.
//   Keeps sticky flags and saturating statistics for slow-control readout.
//   Sits on the DAQ/test side of the link and checks Rider TTS behaviour.
// PARAMETERS
//   STABLE_CYCLES  4   consecutive identical synchronised samples needed to accept a code (>=1)
//   CNT_W          16  width of all statistics counters
// PORTS
//   clk               in   1      single clock; all logic on rising edge
//   reset             in   1      synchronous, active-high
//   tts_in            in   4      raw TTS code; asynchronous to clk
//   clr_stats         in   1      1-cycle pulse; clears sticky flags and counters
//   tts_class         out  3      accepted class: 0 DISC,1 ERROR,2 SYNC_LOST,3 BUSY,4 OFW,5 READY,6 INVALID
//   state_change      out  1      1-cycle pulse when tts_class changes
//   err_seen          out  1      sticky; ERROR class was accepted
//   sync_seen         out  1      sticky; SYNC_LOST class was accepted
//   ofw_seen          out  1      sticky; OFW class was accepted
//   invalid_seen      out  1      sticky; INVALID class was accepted
//   err_count         out  CNT_W  number of entries into ERROR, saturating
//   sync_count        out  CNT_W  number of entries into SYNC_LOST, saturating
//   not_ready_cycles  out  CNT_W  cycles with tts_class != READY, saturating
// BEHAVIOUR
//   - Decode: 0000/1111->DISC, 1100->ERROR, 0010->SYNC_LOST, 0100->BUSY,
//     0001->OFW, 1000->READY, any other code->INVALID.
//   - tts_in goes through a 2-flop synchroniser. A code is accepted once the
//     synchronised value has held the same code for STABLE_CYCLES consecutive cycles.
//   - Latency: tts_in changes before edge 1 and then holds. tts_class updates on
//     edge 2+STABLE_CYCLES. Shorter pulses are filtered out and change no output.
//   - Any change of the synchronised value restarts the stability count.
//   - An entry is an accepted class that differs from the current tts_class.
//     On an entry: tts_class updates, state_change pulses for that one cycle,
//     the matching sticky flag sets, and err_count/sync_count increments if applicable.
//   - Re-accepting the current class causes no pulse and no count.
//     This includes switching between the two DISC codes 0000 and 1111.
//   - not_ready_cycles increments every cycle in which registered tts_class != READY.
//   - All counters saturate at 2^CNT_W-1 and never wrap.
//   - clr_stats zeroes the sticky flags and counters on the next edge.
//     tts_class and the debounce state are unaffected.
//   - clr_stats coinciding with an entry: the entry is kept. The flag reads 1
//     afterwards and err_count/sync_count reads 1.
//   - clr_stats coinciding with a not_ready_cycles increment: the counter reads 1 afterwards.
//   - Reset, including mid-operation, sets synchroniser flops to 0000, the stability
//     count to 0, tts_class=DISC, state_change=0, and all flags and counters to 0.
//   - After reset, accepting 0000 or 1111 is not an entry.
// TESTING
//   1 Reset, tts_in=1000 held, STABLE_CYCLES=4 -> tts_class=5 at edge 6;
//     state_change high for exactly that cycle; err_count=0.
//   2 READY, then tts_in=1100 for 3 cycles, then back to 1000 -> tts_class stays 5,
//     no state_change pulse, err_seen=0.
//   3 READY, then 1100 held 20 cycles, then 1000 -> ERROR accepted with err_count=1 and
//     err_seen=1. not_ready_cycles counts each ERROR cycle. err_seen stays 1 after READY returns.
//   4 tts_in=0110 held -> tts_class=6 and invalid_seen=1; then 0000 -> tts_class=0.
//   5 CNT_W=4, 20 ERROR/READY alternations -> err_count=15 (saturated, no wrap).
//   6 clr_stats on the cycle ERROR is accepted -> err_count=1, err_seen=1.
//     Then reset mid-ERROR -> tts_class=0, all flags and counters 0, no pulse.

Source files
------------

// File: rtl/tts_monitor.sv
// tts_monitor: synchronise, debounce and decode the TTS link, with sticky flags and saturating stats
module tts_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       tts_in,
    input  logic             clr_stats,
    output logic [2:0]       tts_class,
    output logic             state_change,
    output logic             err_seen,
    output logic             sync_seen,
    output logic             ofw_seen,
    output logic             invalid_seen,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sync_count,
    output logic [CNT_W-1:0] not_ready_cycles
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [2:0] C_DISC = 3'd0, C_ERR = 3'd1, C_SYNC = 3'd2, C_BUSY = 3'd3,
                           C_OFW = 3'd4, C_READY = 3'd5, C_INV = 3'd6;
    logic [3:0]       s1, s2;
    logic [SW-1:0]    cnt;
    logic [2:0]       acc;
    logic             stable, entry;
    logic [CNT_W-1:0] err_base, sync_base, nr_base, err_n, sync_n, nr_n;
    // decode the synchronised code, detect a new class entry and form saturating counter updates
    always_comb begin
        acc = (s2 == 4'b0000 || s2 == 4'b1111) ? C_DISC :
              (s2 == 4'b1100) ? C_ERR :
              (s2 == 4'b0010) ? C_SYNC :
              (s2 == 4'b0100) ? C_BUSY :
              (s2 == 4'b0001) ? C_OFW :
              (s2 == 4'b1000) ? C_READY : C_INV;
        stable = cnt == SW'(STABLE_CYCLES - 1);
        entry = stable && acc != tts_class;
        err_base = clr_stats ? '0 : err_count;
        sync_base = clr_stats ? '0 : sync_count;
        nr_base = clr_stats ? '0 : not_ready_cycles;
        err_n = err_base + CNT_W'(entry && acc == C_ERR && ~&err_base);
        sync_n = sync_base + CNT_W'(entry && acc == C_SYNC && ~&sync_base);
        nr_n = nr_base + CNT_W'(tts_class != C_READY && ~&nr_base);
    end
    // synchroniser, stability count, accepted class and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            cnt <= '0;
            tts_class <= C_DISC;
            state_change <= 1'b0;
            err_seen <= 1'b0;
            sync_seen <= 1'b0;
            ofw_seen <= 1'b0;
            invalid_seen <= 1'b0;
            err_count <= '0;
            sync_count <= '0;
            not_ready_cycles <= '0;
        end else begin
            s1 <= tts_in;
            s2 <= s1;
            cnt <= (s1 != s2) ? '0 : stable ? cnt : cnt + SW'(1);
            tts_class <= entry ? acc : tts_class;
            state_change <= entry;
            err_seen <= (err_seen && !clr_stats) || (entry && acc == C_ERR);
            sync_seen <= (sync_seen && !clr_stats) || (entry && acc == C_SYNC);
            ofw_seen <= (ofw_seen && !clr_stats) || (entry && acc == C_OFW);
            invalid_seen <= (invalid_seen && !clr_stats) || (entry && acc == C_INV);
            err_count <= err_n;
            sync_count <= sync_n;
            not_ready_cycles <= nr_n;
        end
    end
endmodule

// File: tb/tb_tts_monitor.sv
// tb_tts_monitor: randomized and directed checks of tts_monitor against a behavioural model
module tb_tts_monitor;
    localparam int S = 4;
    logic clk = 1'b0, reset = 1'b1, clr_stats = 1'b0;
    logic [3:0] tts_in = 4'h0;
    logic [2:0] cls_a, cls_b;
    logic pulse_a, pulse_b, err_a, err_b, sync_a, sync_b, ofw_a, ofw_b, inv_a, inv_b;
    logic [15:0] errc_a, syncc_a, nr_a;
    logic [3:0] errc_b, syncc_b, nr_b;
    int checks = 0, errors = 0;
    int m_cls, m_pulse, m_err, m_sync, m_ofw, m_inv, m_errc, m_syncc, m_nr;
    logic [3:0] raw[$];
    logic [3:0] yq[$];

    tts_monitor #(.STABLE_CYCLES(S), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .tts_in(tts_in), .clr_stats(clr_stats),
        .tts_class(cls_a), .state_change(pulse_a), .err_seen(err_a), .sync_seen(sync_a),
        .ofw_seen(ofw_a), .invalid_seen(inv_a), .err_count(errc_a), .sync_count(syncc_a),
        .not_ready_cycles(nr_a));

    tts_monitor #(.STABLE_CYCLES(S), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .tts_in(tts_in), .clr_stats(clr_stats),
        .tts_class(cls_b), .state_change(pulse_b), .err_seen(err_b), .sync_seen(sync_b),
        .ofw_seen(ofw_b), .invalid_seen(inv_b), .err_count(errc_b), .sync_count(syncc_b),
        .not_ready_cycles(nr_b));

    always #5 clk = ~clk;

    function automatic int dec(input logic [3:0] c);
        case (c)
            4'b0000, 4'b1111: return 0;
            4'b1100: return 1;
            4'b0010: return 2;
            4'b0100: return 3;
            4'b0001: return 4;
            4'b1000: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        return v > (1 << w) - 1 ? (1 << w) - 1 : v;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // a code is accepted when the last S synchronised samples since reset are all equal
    task automatic model();
        logic [3:0] s2;
        bit st;
        int acc;
        bit entry;
        if (reset) begin
            raw = '{4'h0, 4'h0};
            yq = '{};
            {m_cls, m_pulse, m_err, m_sync, m_ofw, m_inv, m_errc, m_syncc, m_nr} = '0;
        end else begin
            s2 = raw[0];
            yq.push_back(s2);
            if (yq.size() > S) void'(yq.pop_front());
            st = yq.size() == S;
            foreach (yq[i]) if (yq[i] != s2) st = 0;
            acc = dec(s2);
            entry = st && acc != m_cls;
            if (clr_stats) {m_err, m_sync, m_ofw, m_inv, m_errc, m_syncc, m_nr} = '0;
            m_nr += (m_cls != 5);
            if (entry) begin
                m_err |= (acc == 1);
                m_sync |= (acc == 2);
                m_ofw |= (acc == 4);
                m_inv |= (acc == 6);
                m_errc += (acc == 1);
                m_syncc += (acc == 2);
                m_cls = acc;
            end
            m_pulse = entry;
            raw.push_back(tts_in);
            void'(raw.pop_front());
        end
    endtask

    task automatic step(input logic [3:0] code, input logic c, input logic r);
        tts_in = code;
        clr_stats = c;
        reset = r;
        @(posedge clk);
        model();
        #1;
        check("class", cls_a, m_cls);
        check("pulse", pulse_a, m_pulse);
        check("err_seen", err_a, m_err);
        check("sync_seen", sync_a, m_sync);
        check("ofw_seen", ofw_a, m_ofw);
        check("invalid_seen", inv_a, m_inv);
        check("err_count", errc_a, sat(m_errc, 16));
        check("sync_count", syncc_a, sat(m_syncc, 16));
        check("not_ready", nr_a, sat(m_nr, 16));
        check("class_w4", cls_b, m_cls);
        check("pulse_w4", pulse_b, m_pulse);
        check("err_seen_w4", err_b, m_err);
        check("err_count_w4", errc_b, sat(m_errc, 4));
        check("sync_count_w4", syncc_b, sat(m_syncc, 4));
        check("not_ready_w4", nr_b, sat(m_nr, 4));
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        for (int i = 0; i < n; i++) step(code, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] codes[8];
        logic [3:0] c;
        codes = '{4'h0, 4'hf, 4'hc, 4'h2, 4'h4, 4'h1, 4'h8, 4'h6};
        step(4'h0, 1'b0, 1'b1);
        check("reset_class", cls_a, 0);
        check("reset_nr", nr_a, 0);
        for (int i = 1; i <= 5; i++) step(4'h8, 1'b0, 1'b0);
        check("t1_edge5_class", cls_a, 0);
        step(4'h8, 1'b0, 1'b0);
        check("t1_edge6_class", cls_a, 5);
        check("t1_edge6_pulse", pulse_a, 1);
        step(4'h8, 1'b0, 1'b0);
        check("t1_pulse_drop", pulse_a, 0);
        check("t1_err_count", errc_a, 0);
        hold(4'hc, 3);
        hold(4'h8, 10);
        check("t2_filtered", cls_a, 5);
        check("t2_err_seen", err_a, 0);
        hold(4'hc, 20);
        hold(4'h8, 10);
        check("t3_err_count", errc_a, 1);
        check("t3_err_seen", err_a, 1);
        hold(4'h6, 10);
        check("t4_invalid", cls_a, 6);
        check("t4_invalid_seen", inv_a, 1);
        hold(4'h0, 10);
        check("t4_disc", cls_a, 0);
        hold(4'hf, 10);
        check("t4_disc_swap", pulse_a, 0);
        step(4'h8, 1'b1, 1'b0);
        hold(4'h8, 10);
        for (int i = 0; i < 20; i++) begin
            hold(4'hc, S + 3);
            hold(4'h8, S + 3);
        end
        check("t5_sat_w4", errc_b, 15);
        check("t5_w16", errc_a, 20);
        hold(4'hc, S + 1);
        step(4'hc, 1'b1, 1'b0);
        check("t6_clr_entry_count", errc_a, 1);
        check("t6_clr_entry_flag", err_a, 1);
        hold(4'hc, 3);
        step(4'hc, 1'b0, 1'b1);
        check("t6_reset_class", cls_a, 0);
        check("t6_reset_pulse", pulse_a, 0);
        check("t6_reset_err", errc_a, 0);
        hold(4'h0, 10);
        check("t6_no_disc_entry", err_a, 0);
        for (int n = 0; n < 400; n++) begin
            c = codes[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) c = 4'($urandom);
            for (int i = $urandom_range(1, 2 * S + 3); i > 0; i--)
                step(c, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
